// File: rtl/mem_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Load/store one-hot encodings follow {lb,lh,lw,ld,lbu,lhu,lwu} and {sb,sh,sw,sd}.
package mem_pkg;

   localparam int XLEN = 64;

   localparam logic [6:0] LD_LB  = 7'b1000000;
   localparam logic [6:0] LD_LH  = 7'b0100000;
   localparam logic [6:0] LD_LW  = 7'b0010000;
   localparam logic [6:0] LD_LD  = 7'b0001000;
   localparam logic [6:0] LD_LBU = 7'b0000100;
   localparam logic [6:0] LD_LHU = 7'b0000010;
   localparam logic [6:0] LD_LWU = 7'b0000001;

   localparam logic [3:0] ST_SB = 4'b1000;
   localparam logic [3:0] ST_SH = 4'b0100;
   localparam logic [3:0] ST_SW = 4'b0010;
   localparam logic [3:0] ST_SD = 4'b0001;

   // Instruction fetches are always issued as 32-bit zero-extended loads.
   localparam logic [6:0] IFU_LD_TYPE = LD_LWU;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection with bounded LSU priority: the LSU wins ties until it
// has taken LSU_MAX_CONSEC grants in a row while a fetch was waiting.
module mem_arb_pick
   import mem_pkg::*;
#(
   parameter int LSU_MAX_CONSEC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic ifu_valid,
   input  logic lsu_valid,
   output logic ifu_ready,
   output logic lsu_ready
);

   localparam int CW = (LSU_MAX_CONSEC < 1) ? 1 : $clog2(LSU_MAX_CONSEC + 1);

   logic [CW-1:0] lsu_cnt;
   logic          at_limit;

   assign at_limit = (lsu_cnt == CW'(LSU_MAX_CONSEC));

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      ifu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (idle) begin
         if (lsu_valid && !(ifu_valid && at_limit))
            lsu_ready = 1'b1;
         else if (ifu_valid)
            ifu_ready = 1'b1;
      end
   end

   // A ready is only raised toward a valid requester, so ready alone marks a grant.
   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lsu_cnt <= '0;
      end else if (lsu_ready) begin
         if (!ifu_valid)
            lsu_cnt <= '0;
         else if (!at_limit)
            lsu_cnt <= lsu_cnt + 1'b1;
      end else if (ifu_ready) begin
         lsu_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port with
// exactly one transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int LSU_MAX_CONSEC = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [XLEN-1:0] ifu_addr,
   output logic            ifu_rsp_valid,
   output logic [XLEN-1:0] ifu_rsp_data,
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [XLEN-1:0] lsu_addr,
   input  logic [6:0]      lsu_ld_type,
   input  logic [3:0]      lsu_st_type,
   input  logic [XLEN-1:0] lsu_wdata,
   output logic            lsu_rsp_valid,
   output logic [XLEN-1:0] lsu_rsp_data,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   output logic [6:0]      mem_ld_type,
   output logic [3:0]      mem_st_type,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            busy
);

   state_t          state, state_n;
   owner_t          owner;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [6:0]      ld_q;
   logic [3:0]      st_q;
   logic            accept_ifu, accept_lsu;

   mem_arb_pick #(.LSU_MAX_CONSEC(LSU_MAX_CONSEC)) u_pick (
      .clk       (clk),
      .rst_n     (rst_n),
      .idle      (state == IDLE),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .ifu_ready (ifu_req_ready),
      .lsu_ready (lsu_req_ready)
   );

   assign accept_ifu = ifu_req_valid && ifu_req_ready;
   assign accept_lsu = lsu_req_valid && lsu_req_ready;

   always_comb begin
      state_n       = state;
      mem_req_valid = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      ifu_rsp_data  = '0;
      lsu_rsp_data  = '0;
      case (state)
         IDLE:  if (accept_ifu || accept_lsu) state_n = ISSUE;
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_n = WAIT;
         end
         WAIT:  if (mem_rsp_valid) state_n = RESP;
         RESP: begin
            state_n = IDLE;
            if (owner == OWN_LSU) begin
               lsu_rsp_valid = 1'b1;
               lsu_rsp_data  = rdata_q;
            end else begin
               ifu_rsp_valid = 1'b1;
               ifu_rsp_data  = rdata_q;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign mem_addr    = addr_q;
   assign mem_ld_type = ld_q;
   assign mem_st_type = st_q;
   assign mem_wdata   = wdata_q;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= OWN_IFU;
         addr_q  <= '0;
         ld_q    <= '0;
         st_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (accept_lsu) begin
            owner   <= OWN_LSU;
            addr_q  <= lsu_addr;
            // A request carrying both a load and a store type is treated as a store.
            ld_q    <= (|lsu_st_type) ? 7'b0 : lsu_ld_type;
            st_q    <= lsu_st_type;
            wdata_q <= lsu_wdata;
         end else if (accept_ifu) begin
            owner   <= OWN_IFU;
            addr_q  <= ifu_addr;
            ld_q    <= IFU_LD_TYPE;
            st_q    <= '0;
            wdata_q <= '0;
         end
         if (state == WAIT && mem_rsp_valid)
            rdata_q <= (|st_q) ? '0 : mem_rsp_data;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LSU_MAX_CONSEC, default 4: maximum consecutive LSU grants while an IFU request waits.
REQ-002 SHALL have ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- ifu_req_valid, in, 1: fetch request.
- ifu_req_ready, out, 1: fetch request accepted.
- ifu_addr, in, 64: fetch address.
- ifu_rsp_valid, out, 1: fetch data valid (1-cycle pulse).
- ifu_rsp_data, out, 64: fetch data.
- lsu_req_valid, in, 1: load/store request.
- lsu_req_ready, out, 1: load/store request accepted.
- lsu_addr, in, 64: load/store address.
- lsu_ld_type, in, 7: one-hot {lb,lh,lw,ld,lbu,lhu,lwu}.
- lsu_st_type, in, 4: one-hot {sb,sh,sw,sd}.
- lsu_wdata, in, 64: store data.
- lsu_rsp_valid, out, 1: load data or store ack (1-cycle pulse).
- lsu_rsp_data, out, 64: load data; 0 for stores.
- mem_req_valid, out, 1: downstream request.
- mem_req_ready, in, 1: downstream accept.
- mem_addr, out, 64: downstream address.
- mem_ld_type, out, 7: downstream load type.
- mem_st_type, out, 4: downstream store type.
- mem_wdata, out, 64: downstream store data.
- mem_rsp_valid, in, 1: downstream response.
- mem_rsp_data, in, 64: downstream read data.
- busy, out, 1: state != IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with exactly one transaction outstanding at a time.
REQ-004 In IDLE, ready SHALL be asserted combinationally to the selected requester only; acceptance happens on valid&&ready, and the FSM SHALL then move to ISSUE.
REQ-005 Selection rule:
- Only one requester valid: grant it.
- Both valid: grant LSU, unless lsu_cnt == LSU_MAX_CONSEC, in which case grant IFU.
REQ-006 lsu_cnt SHALL be updated on every grant:
- LSU grant while ifu_req_valid is high: increment, saturating at LSU_MAX_CONSEC.
- Any IFU grant, or LSU grant with IFU idle: clear to 0.
REQ-007 On acceptance, the arbiter SHALL register addr, ld_type, st_type, wdata and the owner.
- IFU requests SHALL be issued as ld_type=7'b0000001 (lwu), st_type=0, wdata=0.
REQ-008 LSU request with both ld_type and st_type nonzero SHALL be issued as a store (ld_type forced 0); both zero SHALL be issued unchanged.
REQ-009 In ISSUE, mem_req_valid SHALL be 1, with all mem_* fields held stable until mem_req_ready; on the handshake the FSM SHALL move to WAIT.
REQ-010 mem_rsp_valid SHALL be ignored outside WAIT. In WAIT it SHALL capture mem_rsp_data (0 if store) and move to RESP.
REQ-011 In RESP, the owner's rsp_valid SHALL be 1 for exactly one cycle with the captured data; the other requester's rsp_valid SHALL stay 0. The FSM SHALL then return to IDLE.
REQ-012 Minimum latency from acceptance at cycle N, with ready and response in zero wait states, SHALL be:
- mem_req_valid at N+1.
- Response accepted at N+2.
- rsp_valid at N+3.
- New acceptance possible at N+4.
REQ-013 Requests arriving while the FSM is not IDLE SHALL see ready=0 and SHALL NOT be dropped; the requester holds valid.
REQ-014 rsp_data SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-015 While rst_n=0, the block SHALL hold:
- state=IDLE, lsu_cnt=0.
- All registered fields 0.
- All outputs 0, except ready, which follows REQ-004.
REQ-016 Reset asserted mid-transaction SHALL abandon it: no rsp_valid is emitted for it, and mem_req_valid drops immediately.

Structure
REQ-017 Shared package mem_pkg SHALL hold:
- LD_* and ST_* one-hot constants.
- The IFU_LD_TYPE constant.
- The state enum.
- The 64-bit address/data width constant.
REQ-018 Selection and lsu_cnt update logic SHALL be one sub-module, mem_arb_pick; the FSM and registers stay in mem_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- IFU only, addr 0x80000000, zero-wait memory returning 0x0000_0013 -> ifu_rsp_valid at N+3 with data 0x13, mem_ld_type=7'b0000001.
- IFU and LSU both valid continuously, LSU_MAX_CONSEC=4 -> grant order L,L,L,L,I,L,L,L,L,I.
- LSU sd, addr 0x80001000, wdata 0xDEADBEEF, mem_req_ready held 0 for 3 cycles -> mem_* fields stable for 4 cycles; lsu_rsp_valid with data 0; no ifu_rsp_valid.
- LSU with ld_type=LD and st_type=SW -> mem_ld_type=0, mem_st_type=SW.
- Spurious mem_rsp_valid in IDLE or ISSUE -> no rsp_valid produced.
- rst_n pulled low in WAIT -> outputs 0, state IDLE; a later mem_rsp_valid produces no response.
